// File: rtl/uart_rx_if.sv
// Serial-receive bus between the line/tick source and the UART receiver.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    // Source side: drives the tick and the serial line, observes the result.
    modport master (
        output baud_tick,
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  baud_tick,
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling,
// one-cycle valid strobe per good byte and a one-cycle frame_err strobe
// when the stop bit samples low.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);

    localparam logic [TCNT_W-1:0] TCNT_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath; everything advances only on baud ticks.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (bus.baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    // Detection tick: the start-bit clock begins here.
                    if (!rx_s_q) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end

                START: begin
                    // Mid start bit: confirm low or discard as a glitch.
                    if (tcnt_q == TCNT_HALF) begin
                        tcnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                DATA: begin
                    // One sample per bit period, shifted in LSB first.
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                STOP: begin
                    // Stop-bit sample decides between delivery and error.
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d = '0;
                        if (rx_s_q) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line (break) must not start a new frame.
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered from the next state so busy drops together with valid.
        busy_d = (state_d != IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames fed through a scoreboard,
// plus hand sequences for glitch, framing error/break and mid-frame reset.
module tb_uart_rx;
    localparam int unsigned BIT_CLK = 32;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         bclk;
        int         gap;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   tick_cnt;
    logic [7:0] last_good;
    exp_t sb[$];
    vec_t vecs[8];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick every 4 clk (8 ticks per 32-clk bit).
    initial begin
        tick_cnt      = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt      = (tick_cnt + 1) % 4;
            bus.baud_tick = (tick_cnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; after the start bit the receiver must be busy.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
        bus.rx = 1'b0;
        wait_clk(bclk);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_clk(bclk);
        end
        bus.rx = stop;
        wait_clk(bclk);
    endtask

    task automatic push_good(input logic [7:0] b);
        exp_t e;
        e.is_err  = 1'b0;
        e.d       = b;
        sb.push_back(e);
        last_good = b;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.d      = last_good;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.valid && bus.frame_err) begin
                check("valid_ferr_exclusive", 32'd1, 32'd0);
            end
            if (bus.valid || bus.frame_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse valid=%0b frame_err=%0b data=0x%0h required=no_pulse at %0t",
                             bus.valid, bus.frame_err, bus.data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_is_frame_err", 32'(bus.frame_err), 32'(e.is_err));
                    check("data_at_pulse", 32'(bus.data), 32'(e.d));
                    check("busy_at_pulse", 32'(bus.busy), 32'(e.is_err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        last_good = 8'h00;
        bus.rx    = 1'b1;
        rst_n     = 1'b0;

        vecs[0] = '{din: 8'h55, stop: 1'b1, bclk: 32, gap: 64};
        vecs[1] = '{din: 8'hA3, stop: 1'b1, bclk: 32, gap: 0};
        vecs[2] = '{din: 8'h0F, stop: 1'b1, bclk: 32, gap: 64};
        vecs[3] = '{din: 8'h96, stop: 1'b1, bclk: 33, gap: 64};
        vecs[4] = '{din: 8'h96, stop: 1'b1, bclk: 31, gap: 64};
        vecs[5] = '{din: 8'h00, stop: 1'b1, bclk: 32, gap: 0};
        vecs[6] = '{din: 8'hFF, stop: 1'b1, bclk: 32, gap: 0};
        vecs[7] = '{din: 8'h01, stop: 1'b1, bclk: 32, gap: 64};

        // Reset state.
        wait_clk(4);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        wait_clk(20);

        // Table: basic, back-to-back, +/-3% baud, extremes.
        for (int i = 0; i < 8; i++) begin
            push_good(vecs[i].din);
            send_frame(vecs[i].din, vecs[i].stop, vecs[i].bclk);
            wait_clk(vecs[i].gap);
        end
        check("busy_idle_after_table", 32'(bus.busy), 32'h0);

        // Glitch: low for 2 ticks only.
        bus.rx = 1'b0;
        wait_clk(8);
        check("glitch_busy_rise", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        wait_clk(30);
        check("glitch_busy_fall", 32'(bus.busy), 32'h0);
        check("glitch_data_kept", 32'(bus.data), 32'h01);
        wait_clk(40);
        push_good(8'h81);
        send_frame(8'h81, 1'b1, BIT_CLK);
        wait_clk(64);

        // Framing error followed by a long break, then recovery.
        push_err();
        send_frame(8'hF0, 1'b0, BIT_CLK);
        wait_clk(20 * BIT_CLK);
        check("break_busy", 32'(bus.busy), 32'h1);
        check("break_data_kept", 32'(bus.data), 32'h81);
        bus.rx = 1'b1;
        wait_clk(16);
        check("break_release_busy", 32'(bus.busy), 32'h0);
        wait_clk(32);
        push_good(8'h3C);
        send_frame(8'h3C, 1'b1, BIT_CLK);
        wait_clk(64);

        // Reset during data bit 3 of 0xFF.
        bus.rx = 1'b0;
        wait_clk(BIT_CLK);
        bus.rx = 1'b1;
        wait_clk(3 * BIT_CLK + BIT_CLK / 2);
        check("pre_reset_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(bus.data), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        wait_clk(5);
        rst_n     = 1'b1;
        last_good = 8'h00;
        wait_clk(6 * BIT_CLK);
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check("post_rst_data", 32'(bus.data), 32'h0);
        push_good(8'h42);
        send_frame(8'h42, 1'b1, BIT_CLK);
        wait_clk(64);

        // Drain the scoreboard within a bounded time.
        for (int i = 0; i < 1000 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        check("final_data", 32'(bus.data), 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserializes 8N1 frames from the external serial line into parallel bytes. It is the receiving counterpart of the existing `uart_tx`. It sits in the top-level wrapper next to it and consumes the 8x-oversampled tick from the RX `baud_generator` instance (divider 651 at 50 MHz for 9600 baud). Each received byte is presented with a single-cycle valid strobe, and stop-bit violations are flagged.

## Interface
- `OVERSAMPLE`, default 8: baud_tick pulses per bit period; must be even and ≥4.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.

- `clk` input 1: system clock (50 MHz).
- `rst_n` input 1: asynchronous, active-low reset.
- `baud_tick` input 1: one-`clk`-wide pulse at OVERSAMPLE × baud rate.
- `rx` input 1: asynchronous serial line; idles high.
- `data` output DATA_BITS: last correctly framed byte; holds its value between frames.
- `valid` output 1: one-`clk` pulse when `data` is updated.
- `frame_err` output 1: one-`clk` pulse when the stop bit samples low.
- `busy` output 1: high while a frame is being received.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Tick counter `tcnt` has width $clog2(OVERSAMPLE). Bit counter `bcnt` has width $clog2(DATA_BITS+1). Both advance only on cycles where `baud_tick` = 1.
- State machine has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE, on a tick with `rx_s` = 0: go to START, set `tcnt` = 0, set `busy` = 1. This is the detection tick.
- START: increment `tcnt` each tick. At tick OVERSAMPLE/2 after detection (mid start bit):
  - `rx_s` = 0: go to DATA, clear `tcnt` and `bcnt`.
  - `rx_s` = 1: treat as a glitch, return to IDLE, `busy` = 0. No `valid` or `frame_err` pulse.
- DATA: every OVERSAMPLE ticks, sample `rx_s` into the shift register MSB and shift right, so the first received bit lands in bit 0. Increment `bcnt`. After DATA_BITS samples, go to STOP.
- STOP: after OVERSAMPLE ticks, sample `rx_s`:
  - 1: load the shift register into `data`, pulse `valid`, go to IDLE.
  - 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick sees `rx_s` = 1, then go to IDLE. This prevents a break condition from re-triggering reception.
- `busy` = 1 in START, DATA, STOP and WAIT_HIGH. `busy` = 0 in IDLE.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (async assert, sync-released by the system):
  - state = IDLE, `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - `tcnt`, `bcnt` and the shift register are cleared.
- Reset asserted mid-frame aborts the frame immediately. No `valid` or `frame_err` pulse is produced.
- Sample points, counted in ticks after the detection tick:
  - start bit at OVERSAMPLE/2 (4);
  - data bit i at OVERSAMPLE/2 + OVERSAMPLE·(i+1) (12, 20, …, 68);
  - stop bit at OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS+1) (76).
- `valid`, `frame_err` and `data` update on the `clk` edge after the stop-sample tick edge, i.e. registered, one cycle later.
- `busy` falls in the same cycle that `valid` rises.
- Input-to-detection latency: 2 `clk` (synchronizer) plus up to 1 tick period of quantization.
- A new start bit may be detected on the first tick after returning to IDLE. Back-to-back frames with a single stop bit must be received without loss.
- Detection requires no prior high level in IDLE. IDLE is only entered from reset, after a good stop bit, or from WAIT_HIGH.

## Test plan
- **Basic byte 0x55.** Drive `baud_tick` every 4 clk, 8N1 frame 0x55 at 32 clk/bit. Required: exactly one `valid` pulse, `data` = 0x55, `frame_err` = 0, `busy` high from detection until `valid`.
- **Back-to-back 0xA3 then 0x0F.** Send with no idle gap. Required: two `valid` pulses, `data` = 0xA3 then 0x0F.
- **Glitch rejection.** `rx` low for 2 ticks then high. Required: no `valid`, no `frame_err`, `busy` returns to 0 at tick 4, later frame 0x81 received correctly.
- **Framing error.** Send 0xF0 with stop bit low, then hold `rx` low 20 bit periods, then high, then send 0x3C. Required: one `frame_err` pulse, `data` still the previous value, `busy` high until `rx` returns high, then `data` = 0x3C with `valid`.
- **Reset mid-frame.** Assert `rst_n` = 0 during data bit 3 of 0xFF. Required: all outputs 0 immediately, no pulses afterwards, next frame 0x42 received correctly.
- **Baud tolerance.** Frame 0x96 with the bit period stretched +3% and -3% relative to 8 ticks. Required: `data` = 0x96, `valid` pulse each time.
